// File: rtl/cfg_pkg.sv
// Shared definitions for the LUT configuration loader.
// Holds the loader state encoding and the elaboration-time helpers that
// size counters and derive the frame/word bookkeeping from the parameters.
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int frames_per_word(input int word_width, input int frame_width);
    return word_width / frame_width;
  endfunction

  // Words consumed by one load: the last word may be only partly used.
  function automatic int words_needed(input int chain_length, input int fpw);
    return (chain_length + fpw - 1) / fpw;
  endfunction

endpackage

// File: rtl/cfg_serializer.sv
// Word-to-frame serializer for the LUT configuration loader.
// Holds one host word and shifts it out FRAME_WIDTH bits at a time, LSB
// frame first. It requests the next word while the last frame of the
// current one is still going out, so a continuously valid host sees no
// bubble between words.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clear        empty the buffer (start of a new load)
//   enable       loader is in its LOAD phase
//   more_words   the load still needs at least one more host word
//   flush        the frame now at the output is the last one of the chain
//   word_in      host word, frame 0 in the low FRAME_WIDTH bits
//   word_valid   host word valid
//   word_ready   buffer can take a word this cycle
//   accept       word handshake completes this cycle
//   shift        a frame is presented to the chain this cycle
//   frame        frame presented to the chain
module cfg_serializer
  import cfg_pkg::*;
#(
  parameter int FRAME_WIDTH = 1,
  parameter int WORD_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   more_words,
  input  logic                   flush,
  input  logic [WORD_WIDTH-1:0]  word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic                   accept,
  output logic                   shift,
  output logic [FRAME_WIDTH-1:0] frame
);

  localparam int FPW  = frames_per_word(WORD_WIDTH, FRAME_WIDTH);
  localparam int BC_W = cnt_width(FPW);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(FPW);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

  logic [WORD_WIDTH-1:0] data_buf;
  logic [BC_W-1:0]       buf_cnt;

  always_comb begin
    shift      = enable && (buf_cnt != '0);
    // Ready while at most one frame remains: the refill lands in the same
    // cycle that last frame leaves.
    word_ready = enable && more_words && (buf_cnt <= BC_ONE);
    accept     = word_valid && word_ready;
    frame      = data_buf[FRAME_WIDTH-1:0];
  end

  // The final chain frame also drops any unused frames of the last word,
  // leaving the output at zero once the load is over.
  always_ff @(posedge clk) begin
    if (rst || clear || (shift && flush)) begin
      data_buf <= '0;
      buf_cnt  <= '0;
    end else if (accept) begin
      data_buf <= word_in;
      buf_cnt  <= BC_FULL;
    end else if (shift) begin
      data_buf <= data_buf >> FRAME_WIDTH;
      buf_cnt  <= buf_cnt - BC_ONE;
    end
  end

endmodule

// File: rtl/lut_config_loader.sv
// Configuration-stream front end for a chain of LUT scan registers.
// On start it resets the chain for one cycle, then streams exactly
// CHAIN_LENGTH frames taken from host words into config_in/config_en and
// parks in DONE until the next start. The first frame shifted ends up at
// the far end of the chain.
//
// Ports:
//   config_clk       clock shared with the LUT chain
//   reset            synchronous active-high reset
//   start            load request, honoured only in IDLE or DONE
//   word_in          host configuration word, frame 0 in the low bits
//   word_valid       host word valid
//   word_ready       loader accepts word_in this cycle
//   chain_reset      chain reset, high for the single CLEAR cycle
//   chain_config_en  chain shift enable
//   chain_config_in  frame shifted into the chain
//   busy             high in CLEAR and LOAD
//   done             high in DONE
module lut_config_loader
  import cfg_pkg::*;
#(
  parameter int FRAME_WIDTH  = 1,
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 16
) (
  input  logic                   config_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_WIDTH-1:0]  word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic                   chain_reset,
  output logic                   chain_config_en,
  output logic [FRAME_WIDTH-1:0] chain_config_in,
  output logic                   busy,
  output logic                   done
);

  localparam int FPW          = frames_per_word(WORD_WIDTH, FRAME_WIDTH);
  localparam int WORDS_NEEDED = words_needed(CHAIN_LENGTH, FPW);
  localparam int FC_W         = cnt_width(CHAIN_LENGTH - 1);
  localparam int WC_W         = cnt_width(WORDS_NEEDED);
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(CHAIN_LENGTH - 1);
  localparam logic [FC_W-1:0] FC_ONE     = FC_W'(1);
  localparam logic [WC_W-1:0] WORDS_ALL  = WC_W'(WORDS_NEEDED);
  localparam logic [WC_W-1:0] WC_ONE     = WC_W'(1);

  state_t          state;
  state_t          state_nxt;
  logic [FC_W-1:0] frame_cnt;
  logic [WC_W-1:0] word_cnt;
  logic            begin_load;
  logic            loading;
  logic            last_frame;
  logic            more_words;
  logic            shift;
  logic            accept;
  logic [FRAME_WIDTH-1:0] frame;

  assign last_frame = (frame_cnt == FRAME_LAST);
  assign more_words = (word_cnt < WORDS_ALL);

  cfg_serializer #(
    .FRAME_WIDTH(FRAME_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_serializer (
    .clk       (config_clk),
    .rst       (reset),
    .clear     (begin_load),
    .enable    (loading),
    .more_words(more_words),
    .flush     (last_frame),
    .word_in   (word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .accept    (accept),
    .shift     (shift),
    .frame     (frame)
  );

  assign chain_config_en = shift;
  assign chain_config_in = frame;

  always_ff @(posedge config_clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge config_clk) begin
    if (reset || begin_load) begin
      frame_cnt <= '0;
      word_cnt  <= '0;
    end else begin
      if (accept) begin
        word_cnt <= word_cnt + WC_ONE;
      end
      if (shift) begin
        frame_cnt <= last_frame ? '0 : frame_cnt + FC_ONE;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    begin_load  = 1'b0;
    loading     = 1'b0;
    chain_reset = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_CLEAR;
          begin_load = 1'b1;
        end
      end
      ST_CLEAR: begin
        chain_reset = 1'b1;
        busy        = 1'b1;
        state_nxt   = ST_LOAD;
      end
      ST_LOAD: begin
        busy    = 1'b1;
        loading = 1'b1;
        if (shift && last_frame) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt  = ST_CLEAR;
          begin_load = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// Bench for lut_config_loader: three instances (1-bit frames with chains of
// 16 and 12, 2-bit frames with a chain of 4) share one stimulus stream.
// A frame-queue reference model is compared every cycle, a model LUT chain
// is fed from the DUT outputs, and directed loads are pinned by literals.
module tb_lut_config_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       word_valid = 1'b0;
  logic [7:0] word_in = 8'h00;

  always #5 clk = ~clk;

  logic a_rdy, a_crst, a_en, a_cin, a_busy, a_done;
  logic b_rdy, b_crst, b_en, b_cin, b_busy, b_done;
  logic c_rdy, c_crst, c_en, c_busy, c_done;
  logic [1:0] c_cin;

  lut_config_loader #(.FRAME_WIDTH(1), .WORD_WIDTH(8), .CHAIN_LENGTH(16)) dut_a (
    .config_clk(clk), .reset(reset), .start(start), .word_in(word_in),
    .word_valid(word_valid), .word_ready(a_rdy), .chain_reset(a_crst),
    .chain_config_en(a_en), .chain_config_in(a_cin), .busy(a_busy), .done(a_done));

  lut_config_loader #(.FRAME_WIDTH(1), .WORD_WIDTH(8), .CHAIN_LENGTH(12)) dut_b (
    .config_clk(clk), .reset(reset), .start(start), .word_in(word_in),
    .word_valid(word_valid), .word_ready(b_rdy), .chain_reset(b_crst),
    .chain_config_en(b_en), .chain_config_in(b_cin), .busy(b_busy), .done(b_done));

  lut_config_loader #(.FRAME_WIDTH(2), .WORD_WIDTH(8), .CHAIN_LENGTH(4)) dut_c (
    .config_clk(clk), .reset(reset), .start(start), .word_in(word_in),
    .word_valid(word_valid), .word_ready(c_rdy), .chain_reset(c_crst),
    .chain_config_en(c_en), .chain_config_in(c_cin), .busy(c_busy), .done(c_done));

  logic [2:0] o_rdy, o_crst, o_en, o_busy, o_done;
  assign o_rdy  = {c_rdy,  b_rdy,  a_rdy};
  assign o_crst = {c_crst, b_crst, a_crst};
  assign o_en   = {c_en,   b_en,   a_en};
  assign o_busy = {c_busy, b_busy, a_busy};
  assign o_done = {c_done, b_done, a_done};

  function automatic int cin_of(input int d);
    if (d == 0) return int'(a_cin);
    if (d == 1) return int'(b_cin);
    return int'(c_cin);
  endfunction

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int FWS[3] = '{1, 1, 2};
  int CLS[3] = '{16, 12, 4};
  int ph[3];        // 0 idle, 1 clear, 2 load, 3 done
  int pend[3];      // frames waiting to go out
  int fq[3][16];    // pending frames, oldest at index 0
  int taken[3];
  int shifted[3];
  int chain_val[3]; // model chain, far end in the low bits
  bit armed = 1'b0;

  function automatic int fpw_of(input int d);
    return 8 / FWS[d];
  endfunction

  function automatic int wn_of(input int d);
    return (CLS[d] + fpw_of(d) - 1) / fpw_of(d);
  endfunction

  task automatic model_step(input int d, input logic r, input logic s,
                            input logic v, input logic [7:0] w);
    bit acc;
    if (r) begin
      ph[d] = 0; pend[d] = 0; taken[d] = 0; shifted[d] = 0;
    end else if (ph[d] == 0 || ph[d] == 3) begin
      if (s) begin
        ph[d] = 1; pend[d] = 0; taken[d] = 0; shifted[d] = 0;
      end
    end else if (ph[d] == 1) begin
      ph[d] = 2;
    end else begin
      acc = v && (taken[d] < wn_of(d)) && (pend[d] <= 1);
      if (pend[d] > 0) begin
        for (int i = 0; i < 15; i++) fq[d][i] = fq[d][i+1];
        pend[d]--;
        shifted[d]++;
        if (shifted[d] == CLS[d]) begin
          ph[d] = 3; pend[d] = 0; acc = 1'b0;
        end
      end
      if (acc) begin
        for (int f = 0; f < fpw_of(d); f++)
          fq[d][pend[d] + f] = (int'(w) >> (f * FWS[d])) & ((1 << FWS[d]) - 1);
        pend[d] += fpw_of(d);
        taken[d]++;
      end
    end
  endtask

  always @(posedge clk) begin : compare
    logic r, s, v;
    logic [7:0] w;
    int e_en;
    r = reset; s = start; v = word_valid; w = word_in;
    #1;
    if (r) armed = 1'b1;
    for (int d = 0; d < 3; d++) begin
      model_step(d, r, s, v, w);
      if (armed) begin
        e_en = (ph[d] == 2 && pend[d] > 0) ? 1 : 0;
        chk($sformatf("dut%0d config_en", d), int'(o_en[d]), e_en);
        chk($sformatf("dut%0d config_in", d), cin_of(d), (e_en != 0) ? fq[d][0] : 0);
        chk($sformatf("dut%0d word_ready", d), int'(o_rdy[d]),
            int'(ph[d] == 2 && taken[d] < wn_of(d) && pend[d] <= 1));
        chk($sformatf("dut%0d chain_reset", d), int'(o_crst[d]), int'(ph[d] == 1));
        chk($sformatf("dut%0d busy", d), int'(o_busy[d]), int'(ph[d] == 1 || ph[d] == 2));
        chk($sformatf("dut%0d done", d), int'(o_done[d]), int'(ph[d] == 3));
        if (o_crst[d]) chain_val[d] = 0;
        else if (o_en[d])
          chain_val[d] = (chain_val[d] >> FWS[d]) | (cin_of(d) << ((CLS[d] - 1) * FWS[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  int tr_en[3][0:31], tr_rdy[3][0:31], tr_crst[3][0:31];
  int tr_busy[3][0:31], tr_done[3][0:31], tr_cin[3][0:31];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // start sampled at cycle 0; traces hold cycles 1..n. word w0 is offered
  // through cycle 2, w1 afterwards; word_valid is low for cycles glo..ghi.
  task automatic drive_load(input logic [7:0] w0, input logic [7:0] w1,
                            input int glo, input int ghi, input int n,
                            input int rst_k, input int pulse_k);
    start = 1'b1; reset = 1'b0; word_valid = 1'b1; word_in = w0;
    for (int k = 1; k <= n; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        tr_en[d][k] = int'(o_en[d]);   tr_rdy[d][k]  = int'(o_rdy[d]);
        tr_crst[d][k] = int'(o_crst[d]); tr_busy[d][k] = int'(o_busy[d]);
        tr_done[d][k] = int'(o_done[d]); tr_cin[d][k]  = cin_of(d);
      end
      start = (k == pulse_k);
      reset = (k == rst_k);
      word_in = (k <= 2) ? w0 : w1;
      word_valid = !(k >= glo && k <= ghi);
    end
    start = 1'b0; reset = 1'b0;
  endtask

  initial begin
    int pat;
    int cnt;
    reset = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset dut%0d ready", d), int'(o_rdy[d]), 0);
      chk($sformatf("reset dut%0d chain_reset", d), int'(o_crst[d]), 0);
      chk($sformatf("reset dut%0d en", d), int'(o_en[d]), 0);
      chk($sformatf("reset dut%0d cin", d), cin_of(d), 0);
      chk($sformatf("reset dut%0d busy", d), int'(o_busy[d]), 0);
      chk($sformatf("reset dut%0d done", d), int'(o_done[d]), 0);
    end
    reset = 1'b0;
    repeat (2) tick();

    // Continuous stream, 0xA5 then 0x3C.
    drive_load(8'hA5, 8'h3C, 99, 0, 20, -1, -1);
    pat = 'h3CA5;
    for (int k = 1; k <= 20; k++) begin
      chk("s1 A chain_reset", tr_crst[0][k], int'(k == 1));
      chk("s1 A ready", tr_rdy[0][k], int'(k == 2 || k == 10));
      chk("s1 A en", tr_en[0][k], int'(k >= 3 && k <= 18));
      chk("s1 A busy", tr_busy[0][k], int'(k >= 1 && k <= 18));
      chk("s1 A done", tr_done[0][k], int'(k >= 19));
      if (k >= 3 && k <= 18) chk("s1 A bit", tr_cin[0][k], (pat >> (k - 3)) & 1);
      chk("s1 B en", tr_en[1][k], int'(k >= 3 && k <= 14));
      chk("s1 B ready", tr_rdy[1][k], int'(k == 2 || k == 10));
      chk("s1 B done", tr_done[1][k], int'(k >= 15));
      chk("s1 C en", tr_en[2][k], int'(k >= 3 && k <= 6));
      chk("s1 C done", tr_done[2][k], int'(k >= 7));
    end
    chk("s1 A chain", chain_val[0], 'h3CA5);
    chk("s1 B chain", chain_val[1], 'hCA5);
    chk("s1 C chain", chain_val[2], 'hA5);

    // Restart from DONE, start pulse mid-load ignored by A; C sees 0xE4.
    drive_load(8'hE4, 8'h81, 99, 0, 20, -1, 8);
    chk("s2 A chain_reset c1", tr_crst[0][1], 1);
    chk("s2 A done c1", tr_done[0][1], 0);
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      cnt += tr_en[0][k];
      chk("s2 A done", tr_done[0][k], int'(k >= 19));
    end
    chk("s2 A en count", cnt, 16);
    chk("s2 A chain", chain_val[0], 'h81E4);
    for (int k = 3; k <= 6; k++) begin
      chk("s2 C en", tr_en[2][k], 1);
      chk("s2 C frame", tr_cin[2][k], k - 3);
    end
    chk("s2 C done c7", tr_done[2][7], 1);

    // Backpressure: word_valid low cycles 10..13.
    drive_load(8'h5A, 8'hC3, 10, 13, 24, -1, -1);
    for (int k = 1; k <= 24; k++) begin
      chk("s3 A en", tr_en[0][k], int'((k >= 3 && k <= 10) || (k >= 15 && k <= 22)));
      chk("s3 A done", tr_done[0][k], int'(k >= 23));
      chk("s3 B done", tr_done[1][k], int'(k >= 19));
    end
    chk("s3 A chain", chain_val[0], 'hC35A);

    // Reset during LOAD at cycle 6, then a fresh load.
    drive_load(8'hA5, 8'h3C, 99, 0, 8, 6, -1);
    for (int d = 0; d < 3; d++) begin
      chk("s4 en after reset", tr_en[d][7], 0);
      chk("s4 busy after reset", tr_busy[d][7], 0);
      chk("s4 done after reset", tr_done[d][7], 0);
      chk("s4 ready after reset", tr_rdy[d][7], 0);
    end
    drive_load(8'h96, 8'h0F, 99, 0, 20, -1, -1);
    chk("s5 A done c18", tr_done[0][18], 0);
    chk("s5 A done c19", tr_done[0][19], 1);
    chk("s5 A chain", chain_val[0], 'h0F96);
    chk("s5 B chain", chain_val[1], 'hF96);
    chk("s5 C chain", chain_val[2], 'h96);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 19) == 0);
      word_valid = ($urandom_range(0, 9) < 7);
      word_in = 8'($urandom);
    end
    reset = 1'b0; start = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lut_config_loader.md
Name: lut_config_loader

Overview:
Configuration-stream front end that sits directly upstream of a chain of LUT scan registers. It accepts wide configuration words from a host over a valid/ready handshake, serializes them into FRAME_WIDTH-bit frames, and drives the chain's config_en/config_in. It first clears the chain, then shifts exactly CHAIN_LENGTH frames and reports completion. Downstream LUTs shift one frame per config_clk edge while config_en is high and hold otherwise.

Parameters:
FRAME_WIDTH, 1, bits shifted into the chain per cycle; must match the LUT chain.
WORD_WIDTH, 32, host word width; must be an integer multiple of FRAME_WIDTH.
CHAIN_LENGTH, 16, total frames in the downstream chain (sum over LUTs of MEM_SIZE/FRAME_WIDTH); must be at least 1.
FPW (localparam), WORD_WIDTH/FRAME_WIDTH, frames per word.
WORDS_NEEDED (localparam), ceil(CHAIN_LENGTH/FPW), words consumed per load.

Ports:
config_clk  in  1  single clock for the loader and the chain
reset  in  1  synchronous, active-high reset
start  in  1  request a load; sampled only in IDLE or DONE
word_in  in  WORD_WIDTH  host configuration word; frame 0 is word_in[FRAME_WIDTH-1:0]
word_valid  in  1  word_in valid
word_ready  out  1  loader accepts word_in this cycle
chain_reset  out  1  drives the chain's reset input
chain_config_en  out  1  drives the chain's config_en input
chain_config_in  out  FRAME_WIDTH  drives the chain's config_in input
busy  out  1  high in CLEAR and LOAD
done  out  1  sticky; high in DONE

Behaviour:
- States: IDLE, CLEAR, LOAD, DONE.
- Registers: buf[WORD_WIDTH]; buf_cnt (frames left in buf, 0..FPW); frame_cnt (0..CHAIN_LENGTH-1); word_cnt (0..WORDS_NEEDED).
- Reset, synchronous: state=IDLE and all counters/buf=0. Outputs after reset: word_ready=0, chain_reset=0, chain_config_en=0, chain_config_in=0, busy=0, done=0.
- IDLE or DONE with start=1: go to CLEAR and zero all counters. done drops in the cycle CLEAR is entered.
- CLEAR lasts exactly 1 cycle: chain_reset=1, chain_config_en=0, word_ready=0. It then goes to LOAD.
- chain_reset=0 in every other state.
- LOAD:
  - shift = (buf_cnt!=0); chain_config_en = shift; chain_config_in = buf[FRAME_WIDTH-1:0].
  - word_ready = (word_cnt<WORDS_NEEDED) && (buf_cnt<=1). This prefetch gives zero-bubble streaming.
  - accept = word_valid && word_ready.
  - On accept: buf<=word_in, buf_cnt<=FPW, word_cnt+1. This happens in the same cycle the last frame of the old buf shifts.
  - Else if shift: buf<=buf>>FRAME_WIDTH, buf_cnt-1.
  - On each shift: frame_cnt+1. A shift with frame_cnt==CHAIN_LENGTH-1 moves to DONE and forces buf_cnt=0, discarding any excess frames of the last word.
  - Empty buffer with no valid word: chain_config_en=0 and the chain holds. No frame is lost or duplicated.
- The first frame shifted ends at the far end of the chain. The host therefore sends the last LUT's top frame first.
- DONE: word_ready=0, chain_config_en=0, done=1.
- start in CLEAR or LOAD is ignored.
- reset asserted mid-LOAD: next cycle is IDLE with chain_config_en=0. The chain keeps its partial contents; the next load's CLEAR wipes them.
- Timing from start sampled at cycle 0: CLEAR at cycle 1, first accept at cycle 2, first chain_config_en at cycle 3. With continuous valid, DONE is at cycle 3+CHAIN_LENGTH.

Decomposition:
- Shared package cfg_pkg holds:
  - state encoding (IDLE=0, CLEAR=1, LOAD=2, DONE=3);
  - a clog2-based width helper;
  - the FPW/WORDS_NEEDED computation.
- One natural sub-module, cfg_serializer, holds buf, buf_cnt, ready and shift logic. The FSM and frame/word counters live in the top module.

Test Plan:
- FRAME_WIDTH=1, WORD_WIDTH=8, CHAIN_LENGTH=16; start@0; words 0xA5 then 0x3C; word_valid always high -> chain_reset=1 at cycle 1 only; accepts at cycles 2 and 10; chain_config_en high cycles 3-18 with bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; done=1 from cycle 19; a 16-bit model chain holds 0x3CA5 reversed bit order as specified.
- CHAIN_LENGTH=12, same words -> exactly 12 config_en cycles; word_ready never high after the 2nd accept; the last 4 bits of 0x3C are not shifted; done at cycle 15.
- Backpressure: word_valid low cycles 10-13 -> chain_config_en low cycles 11-14; stream resumes without loss; done at cycle 23.
- reset at cycle 6 mid-LOAD -> cycle 7: IDLE, chain_config_en=0, busy=0, done=0; a fresh start gives a full correct load.
- start pulsed during LOAD is ignored (frame count unchanged). start in DONE -> done=0 and CLEAR next cycle; a second load completes with new data.
- FRAME_WIDTH=2, WORD_WIDTH=8, CHAIN_LENGTH=4, word 0xE4 -> chain_config_in sequence 0,1,2,3 over 4 cycles; done after a single word.
